// File: rtl/tx_sched_pkg.sv
// Shared state encoding and FIFO status-byte field positions for the TX hold scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_IFG   = 2'd3
  } sched_state_t;

  localparam int STAT_SOP_BIT  = 7;
  localparam int STAT_EOP_BIT  = 6;
  localparam int STAT_BVAL_LSB = 0;
  localparam int STAT_BVAL_W   = 3;

endpackage

// File: rtl/tx_frame_counter.sv
// Up/down counter of complete frames held in the FIFO; saturates at both ends.
module tx_frame_counter
  import tx_sched_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_count;

  // Count update; a simultaneous increment and decrement cancel out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= CNT_MIN;
    end else if (i_inc && !i_dec && (r_count != CNT_MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end else if (i_dec && !i_inc && (r_count != CNT_MIN)) begin
      r_count <= r_count - WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tx_hold_sched.sv
// Read-side scheduler for the 10GE TX hold FIFO: frame-gated pop control, inter-frame
// gap, between-frame pause, and underrun / missing-SOP / oversize detection.
module tx_hold_sched
  import tx_sched_pkg::*;
#(
  parameter int FCNT_WIDTH      = 5,
  parameter int IFG_CYCLES      = 2,
  parameter int MAX_FRAME_WORDS = 1200,
  parameter int WCNT_WIDTH      = 11
) (
  input  logic                  clk_xgmii_tx,
  input  logic                  reset_xgmii_tx,
  input  logic                  txhfifo_wen,
  input  logic [7:0]            txhfifo_wstatus,
  input  logic                  txhfifo_wfull,
  input  logic                  txhfifo_walmost_full,
  input  logic [7:0]            txhfifo_rstatus,
  input  logic                  txhfifo_rempty,
  output logic                  txhfifo_ren,
  input  logic                  pause_req,
  output logic                  txsched_sop,
  output logic                  txsched_eop,
  output logic                  txsched_abort,
  output logic                  txsched_underrun,
  output logic                  txsched_sop_err,
  output logic                  txsched_busy,
  output logic [FCNT_WIDTH-1:0] frames_held
);

  localparam int                    IFG_W    = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [IFG_W-1:0]      IFG_LAST = IFG_W'(IFG_CYCLES);
  localparam logic [WCNT_WIDTH-1:0] WCNT_MAX = WCNT_WIDTH'(MAX_FRAME_WORDS);
  localparam sched_state_t          POST_EOP = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;

  sched_state_t            r_state;
  sched_state_t            w_state_nxt;
  logic [WCNT_WIDTH-1:0]   r_word_cnt;
  logic [WCNT_WIDTH-1:0]   w_word_cnt_nxt;
  logic [WCNT_WIDTH-1:0]   w_word_cnt_inc;
  logic [IFG_W-1:0]        r_ifg_cnt;
  logic [IFG_W-1:0]        w_ifg_cnt_nxt;
  logic                    w_ren;
  logic                    w_sop_err;
  logic                    w_underrun;
  logic                    w_abort;
  logic                    w_head_sop;
  logic                    w_head_eop;
  logic                    w_start;
  logic                    w_frame_in;
  logic                    w_frame_out;
  logic [FCNT_WIDTH-1:0]   w_frames_held;
  logic                    w_unused;

  assign w_head_sop     = txhfifo_rstatus[STAT_SOP_BIT];
  assign w_head_eop     = txhfifo_rstatus[STAT_EOP_BIT];
  assign w_word_cnt_inc = r_word_cnt + WCNT_WIDTH'(1);
  // Almost-full lets a partially written frame start (cut-through).
  assign w_start        = !pause_req && !txhfifo_rempty &&
                          ((w_frames_held != {FCNT_WIDTH{1'b0}}) || txhfifo_walmost_full);

  // State, word counter and gap counter registers.
  always_ff @(posedge clk_xgmii_tx) begin
    if (reset_xgmii_tx) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
      r_ifg_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_ifg_cnt  <= w_ifg_cnt_nxt;
    end
  end

  // Next-state, pop enable and error pulses.
  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_ifg_cnt_nxt  = r_ifg_cnt;
    w_ren          = 1'b0;
    w_sop_err      = 1'b0;
    w_underrun     = 1'b0;
    w_abort        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start && w_head_sop) begin
          w_ren          = 1'b1;
          w_word_cnt_nxt = WCNT_WIDTH'(1);
          w_ifg_cnt_nxt  = IFG_W'(1);
          w_state_nxt    = w_head_eop ? POST_EOP : S_READ;
        end else if (w_start) begin
          w_sop_err   = 1'b1;
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (txhfifo_rempty) begin
          w_underrun  = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = S_DRAIN;
        end else begin
          w_ren          = 1'b1;
          w_word_cnt_nxt = w_word_cnt_inc;
          if (w_head_eop) begin
            w_ifg_cnt_nxt = IFG_W'(1);
            w_state_nxt   = POST_EOP;
          end else if (w_word_cnt_inc >= WCNT_MAX) begin
            w_abort     = 1'b1;
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_READ;
          end
        end
      end
      S_DRAIN: begin
        if (!txhfifo_rempty) begin
          w_ren = 1'b1;
          if (w_head_eop) begin
            w_ifg_cnt_nxt = IFG_W'(1);
            w_state_nxt   = POST_EOP;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_IFG: begin
        if (r_ifg_cnt >= IFG_LAST) begin
          w_ifg_cnt_nxt = '0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_ifg_cnt_nxt = r_ifg_cnt + IFG_W'(1);
          w_state_nxt   = S_IFG;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign txhfifo_ren      = w_ren & ~reset_xgmii_tx;
  assign txsched_sop      = txhfifo_ren & w_head_sop & (r_state != S_DRAIN);
  assign txsched_eop      = txhfifo_ren & w_head_eop & (r_state != S_DRAIN);
  assign txsched_abort    = w_abort & ~reset_xgmii_tx;
  assign txsched_underrun = w_underrun & ~reset_xgmii_tx;
  assign txsched_sop_err  = w_sop_err & ~reset_xgmii_tx;
  assign txsched_busy     = (r_state != S_IDLE);
  assign frames_held      = w_frames_held;

  assign w_frame_in  = txhfifo_wen & txhfifo_wstatus[STAT_EOP_BIT] & ~txhfifo_wfull;
  assign w_frame_out = txhfifo_ren & w_head_eop;

  tx_frame_counter #(
    .WIDTH (FCNT_WIDTH)
  ) u_frame_counter (
    .i_clk   (clk_xgmii_tx),
    .i_rst   (reset_xgmii_tx),
    .i_inc   (w_frame_in),
    .i_dec   (w_frame_out),
    .o_count (w_frames_held)
  );

  assign w_unused = ^{txhfifo_wstatus[STAT_SOP_BIT], txhfifo_wstatus[5:0],
                      txhfifo_rstatus[5:STAT_BVAL_W],
                      txhfifo_rstatus[STAT_BVAL_LSB +: STAT_BVAL_W]};

endmodule

// File: tb/tb_tx_hold_sched.sv
// Directed bench for tx_hold_sched: queue-based FIFO, frame-level reference model,
// per-cycle output comparison plus hand-computed checkpoints.
module tb_tx_hold_sched;

  localparam int FW   = 5;
  localparam int IFG  = 2;
  localparam int MAXW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, wen = 1'b0, wfull = 1'b0, walmost = 1'b0;
  logic          rempty = 1'b1, pause = 1'b0;
  logic [7:0]    wstatus = 8'h00, rstatus = 8'h00;
  logic          ren, sop, eop, abort_o, und, serr, busy;
  logic [FW-1:0] fh;

  tx_hold_sched #(
    .FCNT_WIDTH(FW), .IFG_CYCLES(IFG), .MAX_FRAME_WORDS(MAXW), .WCNT_WIDTH(11)
  ) dut (
    .clk_xgmii_tx(clk), .reset_xgmii_tx(rst),
    .txhfifo_wen(wen), .txhfifo_wstatus(wstatus), .txhfifo_wfull(wfull),
    .txhfifo_walmost_full(walmost), .txhfifo_rstatus(rstatus), .txhfifo_rempty(rempty),
    .txhfifo_ren(ren), .pause_req(pause),
    .txsched_sop(sop), .txsched_eop(eop), .txsched_abort(abort_o),
    .txsched_underrun(und), .txsched_sop_err(serr), .txsched_busy(busy),
    .frames_held(fh)
  );

  logic [7:0] fifo_q[$];
  int total = 0, bad = 0, cyc = 0;

  // Reference model: frame-level bookkeeping
  int m_held = 0, m_gap = 0, m_nw = 0;
  bit m_frame = 1'b0, m_drop = 1'b0;

  logic s_ren, s_sop, s_eop, s_ab, s_un, s_se, s_busy;
  logic [FW-1:0] s_fh;
  int c_ren, c_sop, c_eop, c_ab, c_un, c_se, eop_cyc, sop_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clr();
    c_ren = 0; c_sop = 0; c_eop = 0; c_ab = 0; c_un = 0; c_se = 0;
  endtask

  task automatic step();
    bit ne, hsop, heop, inc, dec;
    bit e_ren, e_sop, e_eop, e_ab, e_un, e_se, e_busy;
    int e_fh;
    @(negedge clk);
    ne   = (fifo_q.size() != 0);
    hsop = ne && fifo_q[0][7];
    heop = ne && fifo_q[0][6];
    {e_ren, e_sop, e_eop, e_ab, e_un, e_se} = 6'b0;
    e_busy = m_frame || m_drop || (m_gap > 0);
    e_fh   = m_held;
    if (!rst) begin
      if (m_gap > 0) begin
        m_gap--;
      end else if (m_drop) begin
        if (ne) begin
          e_ren = 1'b1;
          if (heop) begin m_drop = 1'b0; m_gap = IFG; end
        end
      end else if (m_frame) begin
        if (!ne) begin
          e_un = 1'b1; e_ab = 1'b1; m_frame = 1'b0; m_drop = 1'b1;
        end else begin
          e_ren = 1'b1; e_sop = hsop; e_eop = heop; m_nw++;
          if (heop) begin m_frame = 1'b0; m_gap = IFG; end
          else if (m_nw >= MAXW) begin e_ab = 1'b1; m_frame = 1'b0; m_drop = 1'b1; end
        end
      end else if (!pause && ne && (m_held > 0 || walmost)) begin
        if (hsop) begin
          e_ren = 1'b1; e_sop = 1'b1; e_eop = heop; m_nw = 1;
          if (heop) m_gap = IFG; else m_frame = 1'b1;
        end else begin
          e_se = 1'b1; m_drop = 1'b1;
        end
      end
    end
    {s_ren, s_sop, s_eop, s_ab, s_un, s_se, s_busy, s_fh} =
      {ren, sop, eop, abort_o, und, serr, busy, fh};
    chk("cycle_outputs", {s_ren, s_sop, s_eop, s_ab, s_un, s_se, s_busy, s_fh},
        {e_ren, e_sop, e_eop, e_ab, e_un, e_se, e_busy, FW'(e_fh)});
    c_ren += int'(s_ren); c_sop += int'(s_sop); c_eop += int'(s_eop);
    c_ab  += int'(s_ab);  c_un  += int'(s_un);  c_se  += int'(s_se);
    if (s_eop) eop_cyc = cyc;
    if (s_sop) sop_cyc = cyc;
    if (rst) begin
      m_held = 0; m_gap = 0; m_nw = 0; m_frame = 1'b0; m_drop = 1'b0;
    end else begin
      inc = wen && wstatus[6] && !wfull;
      dec = e_ren && heop;
      if (inc && !dec && m_held < (1 << FW) - 1) m_held++;
      else if (dec && !inc && m_held > 0) m_held--;
    end
    @(posedge clk);
    #1;
    if (s_ren === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (wen && !wfull) fifo_q.push_back(wstatus);
    wen     = 1'b0;
    rempty  = (fifo_q.size() == 0);
    rstatus = rempty ? 8'h00 : fifo_q[0];
    cyc++;
  endtask

  task automatic wr(input logic [7:0] st);
    wen = 1'b1; wstatus = st; step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int a_eop;
    int lim;
    // reset
    step(); step();
    chk("reset_busy", s_busy, 0); chk("reset_frames", s_fh, 0); chk("reset_ren", s_ren, 0);
    rst = 1'b0;
    step();

    // single 4-word store-and-forward frame
    clr();
    wr(8'h80); wr(8'h00); wr(8'h00); wr(8'h44);
    chk("t1_fh_at_eop_write", s_fh, 0);
    step();
    chk("t1_fh_rise", s_fh, 1); chk("t1_first_pop", s_ren, 1); chk("t1_first_sop", s_sop, 1);
    run(6);
    chk("t1_ren_count", c_ren, 4); chk("t1_sop_count", c_sop, 1);
    chk("t1_eop_count", c_eop, 1); chk("t1_fh_end", s_fh, 0);

    // pause hold, mid-frame pause ignored, IFG between two frames
    clr(); pause = 1'b1;
    wr(8'h80); wr(8'h00); wr(8'h41); wr(8'h80); wr(8'h42);
    run(3);
    chk("t2_pause_no_pop", c_ren, 0); chk("t2_held_two", s_fh, 2);
    pause = 1'b0; step();
    chk("t2_pause_release", s_ren, 1);
    pause = 1'b1; step();
    chk("t2_pause_midframe", s_ren, 1);
    step();
    chk("t2_a_eop", s_eop, 1);
    a_eop = eop_cyc; pause = 1'b0;
    run(6);
    chk("t2_ifg_gap", sop_cyc - a_eop - 1, IFG);
    chk("t2_eop_count", c_eop, 2); chk("t2_fh_end", s_fh, 0);

    // cut-through start then underrun; late EOP drained silently
    clr();
    wr(8'h80); wr(8'h00); wr(8'h00);
    run(2);
    chk("t3_no_start", c_ren, 0);
    walmost = 1'b1; step(); walmost = 1'b0;
    run(5);
    chk("t3_underrun_once", c_un, 1); chk("t3_abort_once", c_ab, 1);
    chk("t3_busy_drain", s_busy, 1);
    wr(8'h43);
    step();
    chk("t3_late_eop_pop", s_ren, 1); chk("t3_late_eop_silent", s_eop, 0);
    run(3);
    chk("t3_eop_count", c_eop, 0); chk("t3_ren_count", c_ren, 4);
    chk("t3_fh_end", s_fh, 0); chk("t3_idle", s_busy, 0);

    // head without SOP -> sop_err and drain (inner SOP discarded)
    clr();
    wr(8'h00); wr(8'h80); wr(8'h41);
    run(7);
    chk("t4_sop_err", c_se, 1); chk("t4_ren_count", c_ren, 3);
    chk("t4_no_sop", c_sop, 0); chk("t4_no_eop", c_eop, 0); chk("t4_fh_end", s_fh, 0);

    // EOP write and EOP pop in the same cycle; single-word frame follows
    clr();
    wr(8'h80); wr(8'h00); wr(8'h00); wr(8'h41);
    run(3);
    wr(8'hC0);
    chk("t5_eop_pop", s_eop, 1);
    step();
    chk("t5_simul_hold", s_fh, 1);
    run(2);
    chk("t5_single_word", {s_sop, s_eop}, 2'b11);
    run(3);
    chk("t5_fh_end", s_fh, 0);

    // oversize frame aborts; a frame of exactly the maximum length does not
    clr();
    wr(8'h80); for (int i = 0; i < 6; i++) wr(8'h00); wr(8'h41);
    run(12);
    chk("t6_over_abort", c_ab, 1); chk("t6_over_no_und", c_un, 0);
    chk("t6_over_no_eop", c_eop, 0); chk("t6_over_ren", c_ren, 8);
    clr();
    wr(8'h80); for (int i = 0; i < 4; i++) wr(8'h00); wr(8'h41);
    run(10);
    chk("t6_max_no_abort", c_ab, 0); chk("t6_max_eop", c_eop, 1); chk("t6_max_ren", c_ren, 6);

    // reset mid-READ, then drain the headless remainder with frames_held pinned at 0
    clr();
    wr(8'h80); wr(8'h00); wr(8'h00); wr(8'h00); wr(8'h41);
    run(2);
    rst = 1'b1; step();
    chk("t7_rst_ren", s_ren, 0);
    rst = 1'b0; step();
    chk("t7_busy", s_busy, 0); chk("t7_fh", s_fh, 0); chk("t7_ren", s_ren, 0);
    clr();
    walmost = 1'b1; step(); walmost = 1'b0;
    chk("t7_sop_err", s_se, 1);
    run(6);
    chk("t7_drain_ren", c_ren, 3); chk("t7_fh_sat0", s_fh, 0);
    chk("t7_fifo_empty", fifo_q.size(), 0);

    // EOP write while full is not counted
    wfull = 1'b1; wr(8'hC0); wfull = 1'b0;
    step();
    chk("t8_wfull_fh", s_fh, 0); chk("t8_wfull_ren", s_ren, 0);

    lim = 0;
    while (s_busy !== 1'b0 && lim < 20) begin step(); lim++; end
    chk("final_idle_timeout", (lim < 20), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_hold_sched.md
Name: tx_hold_sched

Overview:
Read-side controller for the TX hold FIFO in the 10GE MAC transmit path, clocked on the XGMII TX clock. Tracks the number of complete frames held, using the write-side EOP markers. Starts a frame read when a whole frame is buffered (store-and-forward) or the FIFO is almost full (cut-through). Generates the FIFO read enable, enforces a minimum inter-frame gap, honours a between-frame pause, and detects underrun, missing-SOP and oversize frames.

Parameters:
FCNT_WIDTH, 5, width of held-frame counter; must cover FIFO depth in words.
IFG_CYCLES, 2, idle cycles forced after each EOP pop; 0 means no gap.
MAX_FRAME_WORDS, 1200, largest legal frame in 64-bit words (9600-byte jumbo).
WCNT_WIDTH, 11, width of per-frame word counter.

Ports:
clk_xgmii_tx  in  1  XGMII TX clock; the only clock
reset_xgmii_tx  in  1  synchronous, active-high reset
txhfifo_wen  in  1  FIFO write enable (observed)
txhfifo_wstatus  in  8  FIFO write status (observed)
txhfifo_wfull  in  1  FIFO full
txhfifo_walmost_full  in  1  FIFO almost full
txhfifo_rstatus  in  8  status of head word, valid while rempty=0
txhfifo_rempty  in  1  FIFO empty
txhfifo_ren  out  1  FIFO pop, combinational
pause_req  in  1  inhibit start of new frames
txsched_sop  out  1  popped word is SOP
txsched_eop  out  1  popped word is EOP
txsched_abort  out  1  1-cycle pulse: current frame terminated in error
txsched_underrun  out  1  1-cycle pulse: FIFO empty mid-frame
txsched_sop_err  out  1  1-cycle pulse: head word in IDLE lacks SOP
txsched_busy  out  1  state != IDLE
frames_held  out  FCNT_WIDTH  complete frames in FIFO

Behaviour:
- Status byte: bit7 SOP, bit6 EOP, bits2:0 valid bytes in last word (0 = 8). Bit 7 of rstatus is tested as "SOP"; bit 6 as "EOP".
- Reset: state IDLE; frames_held, ifg_cnt and word_cnt = 0; all pulse outputs 0; txhfifo_ren = 0 while reset is high.
- frames_held: +1 on txhfifo_wen & wstatus.EOP & !wfull. -1 on txhfifo_ren & rstatus.EOP. Both in one cycle: unchanged. Saturates at 0 and at all-ones, never wraps.
- FIFO read semantics (EARLY_READ): head word is visible while rempty=0; ren pops it with zero latency. txsched_sop/eop = ren & rstatus bit.
- IDLE: start when !pause_req & !rempty & (frames_held != 0 | walmost_full).
  - If head SOP=1: pop it this cycle, set word_cnt=1, go READ. If the same word also has EOP (single-word frame), go IFG/IDLE instead.
  - If head SOP=0: pulse sop_err, go DRAIN, no pop this cycle.
- READ: ren = !rempty.
  - Pop with EOP: go IFG (or IDLE if IFG_CYCLES=0).
  - rempty: pulse underrun and abort, go DRAIN.
  - word_cnt reaching MAX_FRAME_WORDS without EOP: pulse abort, go DRAIN.
  - pause_req is ignored mid-frame.
- DRAIN: ren = !rempty. Discards words until a word with EOP is popped, then goes IFG. Emits no sop/eop outputs while draining. A SOP seen in DRAIN is discarded.
- IFG: ren = 0; ifg_cnt counts 1..IFG_CYCLES, then IDLE. The earliest next SOP pop is IFG_CYCLES+1 cycles after the EOP pop.
- Reset mid-frame: immediate return to IDLE, counters cleared. FIFO contents are the FIFO's own reset concern.
- The write side never blocks: the writer must respect wfull.

Decomposition:
- Package tx_sched_pkg: state enum {S_IDLE, S_READ, S_DRAIN, S_IFG}; constants STAT_SOP_BIT=7, STAT_EOP_BIT=6, STAT_BVAL_LSB=0, STAT_BVAL_W=3.
- One sub-module, tx_frame_counter: up/down saturating counter for frames_held.

Test Plan:
- Write one 4-word frame (SOP on word 0, EOP on word 3) with wen back-to-back → frames_held 0→1 on the cycle after the EOP write. ren high for exactly 4 cycles starting the following cycle; sop on pop 1, eop on pop 4; frames_held returns to 0.
- Two frames queued, IFG_CYCLES=2 → exactly 2 ren-low cycles between eop of frame 1 and sop of frame 2.
- Write SOP+2 words, hold EOP, force walmost_full=1 → cut-through start; FIFO empties mid-frame → underrun and abort pulse once, state DRAIN. The late EOP word is then popped silently, followed by the IFG.
- Head word without SOP in IDLE → sop_err pulse; words popped up to and including the next EOP; no sop/eop outputs.
- pause_req=1 with a frame held → ren stays 0. Raising pause_req mid-frame does not stop the frame. Deassert → start within 1 cycle.
- Simultaneous EOP write and EOP pop with frames_held=1 → stays 1. Reset asserted mid-READ → next cycle ren=0, busy=0, frames_held=0.
